// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Parses UART load frames (0xA5 sync, ADDR, LEN words, LEN*4 little-endian
//   data bytes, CSUM = XOR of ADDR, LEN and data) into 32-bit program-RAM
//   writes, and holds the CPU in reset until a frame loads cleanly.
//   Optional feature macro: UART_LOADER_ECHO_EN. When defined, an ACK (0x06)
//   or NAK (0x15) status byte is sent to the UART transmitter after every frame
//   or timeout. When undefined, tx_start/tx_data are tied to 0.
module uart_boot_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         TMO_W     = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        words_left;
    logic [1:0]        byte_idx;
    logic [23:0]       word_lo;     // bytes 0..2 of the word; byte 3 comes straight from rx_data
    logic [7:0]        csum;
    logic [TMO_W-1:0]  tmo_cnt;

    logic in_frame, sync_seen, word_last, csum_ok, tmo_hit;
    logic ram_we_d, load_done_d, load_err_d;

    assign in_frame  = (state_q == S_ADDR) || (state_q == S_LEN) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
    assign sync_seen = (state_q == S_IDLE) && rx_done && (rx_data == SYNC_BYTE);
    assign word_last = (state_q == S_DATA) && rx_done && (byte_idx == 2'd3);
    assign csum_ok   = (rx_data == csum);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit   = in_frame && !rx_done && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // State register
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic: byte-driven transitions, plus timeout and response handshake
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
`ifdef UART_LOADER_ECHO_EN
            state_d = S_RESP;
`else
            state_d = S_IDLE;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (sync_seen) state_d = S_ADDR;
                S_ADDR: if (rx_done)   state_d = S_LEN;
                S_LEN:  if (rx_done)   state_d = (rx_data == 8'd0) ? S_CSUM : S_DATA;
                S_DATA: if (word_last && words_left == 8'd1) state_d = S_CSUM;
                S_CSUM: if (rx_done) begin
`ifdef UART_LOADER_ECHO_EN
                    state_d = S_RESP;
`else
                    state_d = S_IDLE;
`endif
                end
`ifdef UART_LOADER_ECHO_EN
                S_RESP: if (!tx_busy) state_d = S_IDLE;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode: next-cycle values of the single-cycle strobes
    always_comb begin
        ram_we_d    = word_last;
        load_done_d = (state_q == S_CSUM) && rx_done && csum_ok;
        load_err_d  = ((state_q == S_CSUM) && rx_done && !csum_ok) || tmo_hit;
    end

    // Inter-byte timeout counter: cleared by every byte, runs only mid-frame
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                       tmo_cnt <= '0;
        else if (rx_done || !in_frame || tmo_hit) tmo_cnt <= '0;
        else                                  tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // Frame parser datapath: address, word count, byte lanes and running checksum
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_addr   <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            word_lo    <= '0;
            csum       <= '0;
        end else if (rx_done) begin
            case (state_q)
                S_IDLE: if (rx_data == SYNC_BYTE) csum <= '0;
                S_ADDR: begin
                    cur_addr <= ADDR_W'(rx_data);
                    csum     <= csum ^ rx_data;
                end
                S_LEN: begin
                    words_left <= rx_data;
                    byte_idx   <= '0;
                    csum       <= csum ^ rx_data;
                end
                S_DATA: begin
                    csum     <= csum ^ rx_data;
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    word_lo[7:0]   <= rx_data;
                        2'd1:    word_lo[15:8]  <= rx_data;
                        2'd2:    word_lo[23:16] <= rx_data;
                        default: begin
                            cur_addr   <= cur_addr + ADDR_W'(1);
                            words_left <= words_left - 8'd1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Registered outputs: RAM write port, status pulses and CPU release
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_run   <= 1'b0;
        end else begin
            ram_we    <= ram_we_d;
            load_done <= load_done_d;
            load_err  <= load_err_d;
            if (ram_we_d) begin
                ram_addr  <= cur_addr;
                ram_wdata <= {rx_data, word_lo};
            end
            if (load_done_d)    cpu_run <= 1'b1;
            else if (sync_seen) cpu_run <= 1'b0;
        end
    end

`ifdef UART_LOADER_ECHO_EN
    logic resp_ok;

    // Status echo: remember the frame verdict, then send ACK/NAK once the transmitter is free
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            resp_ok  <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            if (tmo_hit)                               resp_ok <= 1'b0;
            else if ((state_q == S_CSUM) && rx_done)   resp_ok <= csum_ok;
            if ((state_q == S_RESP) && !tx_busy) begin
                tx_start <= 1'b1;
                tx_data  <= resp_ok ? 8'h06 : 8'h15;
            end
        end
    end
`else
    wire unused_tx_busy = tx_busy;

    assign tx_start = 1'b0;
    assign tx_data  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader
//   Directed frames with hand-computed expectations pushed into scoreboard
//   queues; a negedge monitor pops and compares on every DUT strobe.
module tb_uart_boot_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 100;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              rx_done   = 1'b0;
    logic [7:0]        rx_data   = 8'h00;
    logic              tx_busy   = 1'b0;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              cpu_run;
    logic              load_done;
    logic              load_err;
    logic              tx_start;
    logic [7:0]        tx_data;

    uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .load_err  (load_err),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    typedef enum logic {EV_DONE, EV_ERR} ev_e;

    wr_t        exp_wr[$];
    ev_e        exp_ev[$];
    logic [7:0] exp_tx[$];
    logic [7:0] frame[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         tx_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got a pulse, expected none", name);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        exp_wr.push_back('{addr: a, data: d});
    endtask

    task automatic push_ev(input ev_e e);
        exp_ev.push_back(e);
`ifdef UART_LOADER_ECHO_EN
        exp_tx.push_back(e == EV_DONE ? 8'h06 : 8'h15);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge sys_clk);
        rx_done = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
    endtask

    // Monitor: compare every strobe against the scoreboard and enforce single-cycle pulses
    logic prev_we = 1'b0, prev_done = 1'b0, prev_err = 1'b0, prev_tx = 1'b0;
    wr_t  mon_wr;
    ev_e  mon_ev;
    logic [7:0] mon_tx;

    always @(negedge sys_clk) begin
        if (ram_we) begin
            check("ram_we_single", prev_we, 0);
            if (exp_wr.size() == 0) unexpected("ram_we");
            else begin
                mon_wr = exp_wr.pop_front();
                check("ram_addr", ram_addr, mon_wr.addr);
                check("ram_wdata", ram_wdata, mon_wr.data);
            end
        end
        if (load_done || load_err) begin
            if (load_done) check("load_done_single", prev_done, 0);
            if (load_err)  check("load_err_single", prev_err, 0);
            if (exp_ev.size() == 0) unexpected("load_status");
            else begin
                mon_ev = exp_ev.pop_front();
                check("load_done", load_done, mon_ev == EV_DONE);
                check("load_err", load_err, mon_ev == EV_ERR);
            end
        end
        if (tx_start) begin
            tx_cnt++;
            check("tx_start_single", prev_tx, 0);
            if (exp_tx.size() == 0) unexpected("tx_start");
            else begin
                mon_tx = exp_tx.pop_front();
                check("tx_data", tx_data, mon_tx);
            end
        end
        prev_we   = ram_we;
        prev_done = load_done;
        prev_err  = load_err;
        prev_tx   = tx_start;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ram_we"},    ram_we, 0);
        check({tag, "_ram_addr"},  ram_addr, 0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
        check({tag, "_cpu_run"},   cpu_run, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_err"},  load_err, 0);
        check({tag, "_tx_start"},  tx_start, 0);
    endtask

    initial begin
        int lat;
        int tx_base;

        // Reset state
        repeat (3) @(negedge sys_clk);
        check_outputs_zero("reset");
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Good frame
        push_wr(8'h10, 32'h44332211);
        push_wr(8'h11, 32'h88776655);
        push_ev(EV_DONE);
        frame = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h9A};
        send_frame();
        check("good_cpu_run", cpu_run, 1);

        // Same frame, bad checksum: writes still land, error reported
        push_wr(8'h10, 32'h44332211);
        push_wr(8'h11, 32'h88776655);
        push_ev(EV_ERR);
        frame[11] = 8'h00;
        send_frame();
        check("badcsum_cpu_run", cpu_run, 0);

        // Address wrap 0xFF -> 0x00
        push_wr(8'hFF, 32'h04030201);
        push_wr(8'h00, 32'h08070605);
        push_ev(EV_DONE);
        frame = {8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08, 8'hF5};
        send_frame();
        check("wrap_cpu_run", cpu_run, 1);

        // Garbage before sync, zero-length frame
        push_ev(EV_DONE);
        frame = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h20, 8'h00, 8'h20};
        send_frame();
        check("len0_cpu_run", cpu_run, 1);
        push_ev(EV_ERR);   // the lone sync below is left to time out
        send_byte(8'hA5);
        check("sync_drops_cpu_run", cpu_run, 0);
        repeat (120) @(negedge sys_clk);

        // Timeout latency from the last byte
        push_ev(EV_ERR);
        send_byte(8'hA5);
        @(negedge sys_clk);
        rx_data = 8'h10;
        rx_done = 1'b1;
        @(posedge sys_clk);
        lat = 0;
        @(negedge sys_clk);
        rx_done = 1'b0;
        while (!load_err && lat < 300) begin
            @(posedge sys_clk);
            lat++;
            @(negedge sys_clk);
        end
        check("timeout_latency", lat, TIMEOUT);
        check("timeout_cpu_run", cpu_run, 0);
        repeat (5) @(negedge sys_clk);

        // Good frame loads after a timeout
        push_wr(8'h10, 32'h44332211);
        push_wr(8'h11, 32'h88776655);
        push_ev(EV_DONE);
        frame = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h9A};
        send_frame();
        check("after_timeout_cpu_run", cpu_run, 1);

        // Reset mid-DATA: everything clears and no further writes appear
        frame = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22};
        send_frame();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check_outputs_zero("midreset");
        sys_rst_n = 1'b1;
        repeat (150) @(negedge sys_clk);

`ifdef UART_LOADER_ECHO_EN
        // Echo held off by a busy transmitter: ACK, then NAK
        for (int k = 0; k < 2; k++) begin
            tx_busy = 1'b1;
            push_wr(8'h10, 32'h44332211);
            push_wr(8'h11, 32'h88776655);
            push_ev(k == 0 ? EV_DONE : EV_ERR);
            frame = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                     8'h55, 8'h66, 8'h77, 8'h88, (k == 0) ? 8'h9A : 8'h00};
            tx_base = tx_cnt;
            send_frame();
            repeat (46) @(negedge sys_clk);
            check("no_tx_while_busy", tx_cnt, tx_base);
            tx_busy = 1'b0;
            @(posedge sys_clk);
            @(negedge sys_clk);
            check("tx_start_after_busy", tx_start, 1);
            check("echo_tx_data", tx_data, (k == 0) ? 8'h06 : 8'h15);
            repeat (5) @(negedge sys_clk);
        end
`else
        tx_base = tx_cnt;
        check("tx_data_tied", tx_data, 0);
        check("tx_never_started", tx_base, 0);
`endif

        check("pending_writes", exp_wr.size(), 0);
        check("pending_events", exp_ev.size(), 0);
        check("pending_tx", exp_tx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
